mem_access_stage: RTL and testbench

MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM outputs: control bits, ALU result used as the address, store data and destination register. It runs the data-memory transaction over a req/gnt/rvalid handshake and stalls the front of the pipeline while the transaction is outstanding. It also acts as the MEM/WB register, presenting registered results to write-back.

---
 rtl/mem_access_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage / MEM-WB register: runs one req/gnt/rvalid data-memory transaction at a time, with a timeout.
// Latency: non-mem ops retire 1 cycle after issue; mem ops stall upstream until gnt, rvalid or timeout.
module mem_access_stage #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             memwrite_i,
   input  logic             memtoreg_i,
   input  logic             regwrite_i,
   input  logic [WIDTH-1:0] resultop_i,
   input  logic [WIDTH-1:0] wrdata_i,
   input  logic [4:0]       ard_i,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   output logic [WIDTH-1:0] dmem_addr_o,
   output logic [WIDTH-1:0] dmem_wdata_o,
   input  logic             dmem_gnt_i,
   input  logic             dmem_rvalid_i,
   input  logic [WIDTH-1:0] dmem_rdata_i,
   output logic             stall_o,
   output logic             regwrite_o,
   output logic             memtoreg_o,
   output logic [WIDTH-1:0] resultop_o,
   output logic [WIDTH-1:0] readdata_o,
   output logic [4:0]       ard_o,
   output logic             misalign_o,
   output logic             bus_err_o
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             regwrite_q, regwrite_d;
   logic             memtoreg_q, memtoreg_d;
   logic [WIDTH-1:0] resultop_q, resultop_d;
   logic [WIDTH-1:0] readdata_q, readdata_d;
   logic [4:0]       ard_q, ard_d;
   logic             misalign_q, misalign_d;
   logic             bus_err_q, bus_err_d;
   logic             req, stall;

   logic mem_op, aligned, cnt_last;
   assign mem_op   = memwrite_i | memtoreg_i;
   assign aligned  = (resultop_i[1:0] == 2'b00);
   assign cnt_last = (cnt_q == CNT_LAST);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      req        = 1'b0;
      stall      = 1'b0;
      // Default is a bubble: WB sees no write, datapath fields hold.
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      resultop_d = resultop_q;
      readdata_d = readdata_q;
      ard_d      = ard_q;
      misalign_d = 1'b0;
      bus_err_d  = bus_err_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!mem_op) begin
               regwrite_d = regwrite_i;
               memtoreg_d = memtoreg_i;
               resultop_d = resultop_i;
               ard_d      = ard_i;
               readdata_d = '0;
            end else if (!aligned) begin
               misalign_d = 1'b1;
               resultop_d = resultop_i;
               ard_d      = ard_i;
               readdata_d = '0;
            end else begin
               stall   = 1'b1;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (cnt_last) begin
               // Request withdrawn on the final cycle; a grant here could not be honoured.
               bus_err_d  = 1'b1;
               resultop_d = resultop_i;
               ard_d      = ard_i;
               readdata_d = '0;
               cnt_d      = '0;
               state_d    = S_IDLE;
            end else begin
               req = 1'b1;
               if (dmem_gnt_i && memwrite_i) begin
                  regwrite_d = regwrite_i;
                  resultop_d = resultop_i;
                  ard_d      = ard_i;
                  readdata_d = '0;
                  cnt_d      = '0;
                  state_d    = S_IDLE;
               end else begin
                  stall = 1'b1;
                  if (dmem_gnt_i) state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (dmem_rvalid_i) begin
               regwrite_d = regwrite_i;
               memtoreg_d = 1'b1;
               resultop_d = resultop_i;
               ard_d      = ard_i;
               readdata_d = dmem_rdata_i;
               cnt_d      = '0;
               state_d    = S_IDLE;
            end else if (cnt_last) begin
               bus_err_d  = 1'b1;
               resultop_d = resultop_i;
               ard_d      = ard_i;
               readdata_d = '0;
               cnt_d      = '0;
               state_d    = S_IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         resultop_q <= '0;
         readdata_q <= '0;
         ard_q      <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         regwrite_q <= regwrite_d;
         memtoreg_q <= memtoreg_d;
         resultop_q <= resultop_d;
         readdata_q <= readdata_d;
         ard_q      <= ard_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

   // Reset kills the request and stall in the same cycle it is asserted.
   assign dmem_req_o   = req & rst;
   assign stall_o      = stall & rst;
   assign dmem_we_o    = memwrite_i;
   assign dmem_addr_o  = resultop_i;
   assign dmem_wdata_o = wrdata_i;
   assign regwrite_o   = regwrite_q;
   assign memtoreg_o   = memtoreg_q;
   assign resultop_o   = resultop_q;
   assign readdata_o   = readdata_q;
   assign ard_o        = ard_q;
   assign misalign_o   = misalign_q;
   assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the driver predicts each instruction's retirement, a monitor checks it.
module tb_mem_access_stage;
   localparam int W  = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          memwrite_i, memtoreg_i, regwrite_i;
   logic [W-1:0]  resultop_i, wrdata_i;
   logic [4:0]    ard_i;
   logic          dmem_req_o, dmem_we_o;
   logic [W-1:0]  dmem_addr_o, dmem_wdata_o;
   logic          dmem_gnt_i, dmem_rvalid_i;
   logic [W-1:0]  dmem_rdata_i;
   logic          stall_o, regwrite_o, memtoreg_o;
   logic [W-1:0]  resultop_o, readdata_o;
   logic [4:0]    ard_o;
   logic          misalign_o, bus_err_o;

   always #5 clk = ~clk;

   mem_access_stage #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .memwrite_i(memwrite_i), .memtoreg_i(memtoreg_i), .regwrite_i(regwrite_i),
      .resultop_i(resultop_i), .wrdata_i(wrdata_i), .ard_i(ard_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
      .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .stall_o(stall_o), .regwrite_o(regwrite_o), .memtoreg_o(memtoreg_o),
      .resultop_o(resultop_o), .readdata_o(readdata_o), .ard_o(ard_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   typedef struct {
      logic          rw;
      logic          mtr;
      logic [W-1:0]  res;
      logic [W-1:0]  rdata;
      logic [4:0]    ard;
      logic          mis;
      logic          berr;
      int            stalls;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   bit   model_berr = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: every un-stalled cycle is a retirement, every stalled cycle must be a bubble.
   initial begin : monitor
      bit   ps;
      int   sc;
      exp_t e;
      sc = 0;
      forever begin
         @(negedge clk); #2;
         ps = stall_o;
         if (mon_en && ps) sc++;
         @(posedge clk); #1;
         if (!mon_en) begin
            sc = 0;
         end else if (ps) begin
            chk("bubble_regwrite", regwrite_o, 0);
            chk("bubble_misalign", misalign_o, 0);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_retire: regwrite_o=%0b resultop_o=%0h", regwrite_o, resultop_o);
         end else begin
            e = exp_q.pop_front();
            chk("regwrite_o", regwrite_o, e.rw);
            chk("memtoreg_o", memtoreg_o, e.mtr);
            chk("resultop_o", resultop_o, e.res);
            chk("readdata_o", readdata_o, e.rdata);
            chk("ard_o",      ard_o,      e.ard);
            chk("misalign_o", misalign_o, e.mis);
            chk("bus_err_o",  bus_err_o,  e.berr);
            chk("stall_cycles", sc, e.stalls);
            sc = 0;
         end
      end
   end

   // g: REQ cycles before gnt; r: WAIT cycles before rvalid (0 = cycle right after gnt).
   task automatic issue(input logic mw, input logic mr, input logic rw, input logic [W-1:0] addr,
                        input logic [W-1:0] wd, input logic [4:0] ard, input int g, input int r,
                        input logic [W-1:0] rdata);
      exp_t e;
      bit   is_mem, done, granted;
      int   reqcnt, waitcnt, cyc;
      is_mem   = (mw | mr) && (addr[1:0] == 2'b00);
      e.res    = addr;
      e.ard    = ard;
      e.rw     = 1'b0;
      e.mtr    = 1'b0;
      e.rdata  = '0;
      e.mis    = 1'b0;
      e.stalls = 0;
      if (!(mw | mr)) begin
         e.rw = rw;
      end else if (addr[1:0] != 2'b00) begin
         e.mis = 1'b1;
      end else if (mw) begin
         if (g <= TO - 2) begin e.rw = rw; e.stalls = 1 + g; end
         else begin model_berr = 1'b1; e.stalls = TO; end
      end else begin
         if (g <= TO - 2 && g + 1 + r <= TO - 1) begin
            e.rw = rw; e.mtr = 1'b1; e.rdata = rdata; e.stalls = 2 + g + r;
         end else begin
            model_berr = 1'b1; e.stalls = TO;
         end
      end
      e.berr = model_berr;
      exp_q.push_back(e);
      memwrite_i   = mw;
      memtoreg_i   = mr;
      regwrite_i   = rw;
      resultop_i   = addr;
      wrdata_i     = wd;
      ard_i        = ard;
      dmem_rdata_i = rdata;
      #1 mon_en = 1'b1;
      reqcnt = 0; waitcnt = 0; cyc = 0; done = 1'b0; granted = 1'b0;
      while (!done) begin
         @(negedge clk);
         dmem_gnt_i    = 1'b0;
         dmem_rvalid_i = 1'b0;
         if (!is_mem) begin
            chk("no_req", dmem_req_o, 0);
         end else if (granted) begin
            if (waitcnt == r) dmem_rvalid_i = 1'b1;
            waitcnt++;
         end else if (dmem_req_o) begin
            if (reqcnt == g) begin
               dmem_gnt_i = 1'b1;
               chk("dmem_we_o",   dmem_we_o,   mw);
               chk("dmem_addr_o", dmem_addr_o, addr);
               if (mw) chk("dmem_wdata_o", dmem_wdata_o, wd);
               if (!mw) granted = 1'b1;
            end
            reqcnt++;
         end
         #1;
         if (!stall_o) done = 1'b1;
         cyc++;
         if (cyc > 200) begin
            errors++;
            $display("FAIL stall_bound: stall_o stuck after %0d cycles", cyc);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      end
      @(posedge clk); #1;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
   endtask

   function automatic int rand_delay();
      if ($urandom_range(0, 7) == 0) return 14 + $urandom_range(0, 6);
      return $urandom_range(0, 3);
   endfunction

   initial begin : driver
      logic [W-1:0] a;
      int           k;
      rst = 1'b0;
      memwrite_i = 0; memtoreg_i = 0; regwrite_i = 0;
      resultop_i = '0; wrdata_i = '0; ard_i = '0;
      dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_regwrite", regwrite_o, 0);
      chk("rst_resultop", resultop_o, 0);
      chk("rst_readdata", readdata_o, 0);
      chk("rst_ard",      ard_o,      0);
      chk("rst_bus_err",  bus_err_o,  0);
      chk("rst_stall",    stall_o,    0);
      rst = 1'b1;

      // Directed cases
      issue(0, 0, 1, 32'h0000_00A5, 32'h0, 5'd7, 0, 0, 32'h0);
      issue(1, 0, 0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd3, 2, 0, 32'h0);
      issue(0, 1, 1, 32'h0000_0200, 32'h0, 5'd5, 1, 2, 32'h1234_5678);
      issue(0, 1, 1, 32'h0000_0202, 32'h0, 5'd9, 0, 0, 32'h5555_AAAA);
      issue(1, 1, 1, 32'h0000_0300, 32'h0BAD_F00D, 5'd4, 0, 0, 32'h0);
      issue(0, 1, 1, 32'h0000_0400, 32'h0, 5'd6, 0, 100, 32'h0);
      issue(1, 0, 1, 32'h0000_0404, 32'h1111_2222, 5'd8, 100, 0, 32'h0);
      issue(0, 0, 1, 32'h0000_0042, 32'h0, 5'd11, 0, 0, 32'h0);

      // Randomized mix
      for (int i = 0; i < 250; i++) begin
         k = $urandom_range(0, 3);
         a = $urandom;
         case (k)
            0: issue(0, 0, 1'($urandom), a, $urandom, 5'($urandom), 0, 0, $urandom);
            1: issue(1, 1'($urandom), 1'($urandom), {a[W-1:2], 2'b00}, $urandom, 5'($urandom),
                     rand_delay(), 0, $urandom);
            2: issue(0, 1, 1'($urandom), {a[W-1:2], 2'b00}, $urandom, 5'($urandom),
                     rand_delay(), rand_delay(), $urandom);
            default: issue(1'($urandom), 1'b1, 1'($urandom), {a[W-1:2], 2'($urandom_range(1, 3))},
                           $urandom, 5'($urandom), 0, 0, $urandom);
         endcase
      end

      // Reset during WAIT, followed by a late rvalid
      #1 mon_en = 1'b0;
      memwrite_i = 0; memtoreg_i = 1; regwrite_i = 1;
      resultop_i = 32'h0000_0500; ard_i = 5'd12; dmem_rdata_i = 32'hCAFE_F00D;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk); dmem_gnt_i = 1'b1;
      @(posedge clk); #1 dmem_gnt_i = 1'b0;
      @(negedge clk); #1;
      chk("wait_stall", stall_o, 1);
      rst = 1'b0;
      #1;
      chk("rst_req_drop",   dmem_req_o, 0);
      chk("rst_stall_drop", stall_o,    0);
      @(posedge clk); #1;
      chk("midrst_regwrite", regwrite_o, 0);
      chk("midrst_memtoreg", memtoreg_o, 0);
      chk("midrst_resultop", resultop_o, 0);
      chk("midrst_readdata", readdata_o, 0);
      chk("midrst_ard",      ard_o,      0);
      chk("midrst_bus_err",  bus_err_o,  0);
      rst = 1'b1;
      memwrite_i = 0; memtoreg_i = 0; regwrite_i = 0;
      resultop_i = '0; ard_i = '0;
      dmem_rvalid_i = 1'b1;
      @(posedge clk); #1;
      chk("late_rvalid_regwrite", regwrite_o, 0);
      chk("late_rvalid_memtoreg", memtoreg_o, 0);
      chk("late_rvalid_readdata", readdata_o, 0);
      chk("late_rvalid_req",      dmem_req_o, 0);
      dmem_rvalid_i = 1'b0;
      model_berr = 1'b0;
      exp_q.delete();
      issue(0, 0, 1, 32'h0000_0777, 32'h0, 5'd13, 0, 0, 32'h0);
      issue(0, 1, 1, 32'h0000_0800, 32'h0, 5'd14, 0, 0, 32'h8765_4321);

      #3;
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
